// File: rtl/i2c_pkg.sv
// Shared I2C definitions: master FSM states and the sensor address agreed with the slave.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        READ,
        MACK,
        STOP,
        DONE
    } i2c_state_t;

    localparam logic [6:0] I2C_SENSOR_ADDR = 7'h64;
    localparam logic       I2C_RD_BIT      = 1'b1;

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-period tick generator: qtick every CLK_DIV clocks plus a 2-bit quarter index.
// Zero latency combinational tick; no backpressure, cleared on transaction accept.
module i2c_qtick #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    output logic       o_qtick,
    output logic [1:0] o_quarter
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_quarter;

    assign o_qtick   = (r_cnt == CW'(CLK_DIV - 1));
    assign o_quarter = r_quarter;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt     <= '0;
            r_quarter <= 2'd0;
        end else if (o_qtick) begin
            r_cnt     <= '0;
            r_quarter <= r_quarter + 2'd1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_master_reader.sv
// Single-shot I2C master reading the 3-byte sensor record; done after 152*CLK_DIV+2 clks.
// No backpressure: start is accepted only in IDLE, no clock stretching or arbitration.
module i2c_master_reader
    import i2c_pkg::*;
#(
    parameter int         CLK_DIV    = 4,
    parameter logic [6:0] SLAVE_ADDR = I2C_SENSOR_ADDR,
    parameter int         NUM_BYTES  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       valid,
    output logic       nack_err,
    output logic [7:0] x_pos,
    output logic [7:0] y_pos,
    output logic [7:0] status
);
    localparam logic [1:0] LAST_IDX  = 2'(NUM_BYTES - 1);
    localparam logic [7:0] ADDR_BYTE = {SLAVE_ADDR, I2C_RD_BIT};

    i2c_state_t r_state;
    logic [2:0] r_bit;
    logic [1:0] r_byte_idx;
    logic [7:0] r_shreg;
    logic [7:0] r_byte0;
    logic [7:0] r_byte1;
    logic [7:0] r_byte2;
    logic       r_nack;
    logic       r_sda_s1;
    logic       r_sda_s2;

    logic       w_qtick;
    logic [1:0] w_quarter;
    logic       w_accept;
    logic       w_sample;
    logic       w_slot_end;
    logic       w_scl_low;
    logic       w_sda_low;

    assign w_accept   = (r_state == IDLE) && start;
    assign w_sample   = w_qtick && (w_quarter == 2'd2);
    assign w_slot_end = w_qtick && (w_quarter == 2'd3);

    i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_accept),
        .o_qtick  (w_qtick),
        .o_quarter(w_quarter)
    );

    // Line levels for the current quarter; registered below, so the bus trails the FSM by one clk.
    always_comb begin
        w_scl_low = 1'b0;
        w_sda_low = 1'b0;
        case (r_state)
            START: w_sda_low = w_quarter[1];
            ADDR: begin
                w_scl_low = ~w_quarter[1];
                w_sda_low = ~ADDR_BYTE[3'd7 - r_bit];
            end
            ADDR_ACK, READ: w_scl_low = ~w_quarter[1];
            MACK: begin
                w_scl_low = ~w_quarter[1];
                w_sda_low = (r_byte_idx != LAST_IDX);
            end
            STOP: begin
                w_scl_low = (w_quarter == 2'd0);
                w_sda_low = ~w_quarter[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_bit      <= 3'd0;
            r_byte_idx <= 2'd0;
            r_shreg    <= 8'h00;
            r_byte0    <= 8'h00;
            r_byte1    <= 8'h00;
            r_byte2    <= 8'h00;
            r_nack     <= 1'b0;
            r_sda_s1   <= 1'b1;
            r_sda_s2   <= 1'b1;
            scl_oe     <= 1'b0;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            valid      <= 1'b0;
            nack_err   <= 1'b0;
            x_pos      <= 8'h00;
            y_pos      <= 8'h00;
            status     <= 8'h00;
        end else begin
            r_sda_s1 <= sda_in;
            r_sda_s2 <= r_sda_s1;
            scl_oe   <= w_scl_low;
            sda_oe   <= w_sda_low;
            done     <= 1'b0;
            valid    <= 1'b0;
            nack_err <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_state <= START;
                    busy    <= 1'b1;
                    r_nack  <= 1'b0;
                end
                START: if (w_slot_end) begin
                    r_state <= ADDR;
                    r_bit   <= 3'd0;
                end
                ADDR: if (w_slot_end) begin
                    if (r_bit == 3'd7) r_state <= ADDR_ACK;
                    r_bit <= r_bit + 3'd1;
                end
                ADDR_ACK: begin
                    if (w_sample) r_nack <= r_sda_s2;
                    if (w_slot_end) begin
                        r_state    <= r_nack ? STOP : READ;
                        r_byte_idx <= 2'd0;
                    end
                end
                READ: begin
                    if (w_sample) r_shreg <= {r_shreg[6:0], r_sda_s2};
                    if (w_slot_end) begin
                        if (r_bit == 3'd7) r_state <= MACK;
                        r_bit <= r_bit + 3'd1;
                    end
                end
                MACK: if (w_slot_end) begin
                    case (r_byte_idx)
                        2'd0:    r_byte0 <= r_shreg;
                        2'd1:    r_byte1 <= r_shreg;
                        default: r_byte2 <= r_shreg;
                    endcase
                    r_byte_idx <= r_byte_idx + 2'd1;
                    r_state    <= (r_byte_idx == LAST_IDX) ? STOP : READ;
                end
                STOP: if (w_slot_end) r_state <= DONE;
                DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                    if (r_nack) begin
                        nack_err <= 1'b1;
                    end else begin
                        valid  <= 1'b1;
                        x_pos  <= r_byte0;
                        y_pos  <= r_byte1;
                        status <= r_byte2;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_reader.sv
// Bench for i2c_master_reader: open-drain bus shared by a CLK_DIV=4 and a CLK_DIV=2 master plus a sensor slave model.
module tb_i2c_master_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    logic       scl_oe_a, sda_oe_a, busy_a, done_a, valid_a, nack_a;
    logic [7:0] x_a, y_a, st_a;
    logic       scl_oe_b, sda_oe_b, busy_b, done_b, valid_b, nack_b;
    logic [7:0] x_b, y_b, st_b;

    logic s_pull = 1'b0;
    wire  scl_bus = ~(scl_oe_a | scl_oe_b);
    wire  sda_bus = ~(sda_oe_a | sda_oe_b | s_pull);

    i2c_master_reader #(.CLK_DIV(4)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .sda_in(sda_bus),
        .scl_oe(scl_oe_a), .sda_oe(sda_oe_a), .busy(busy_a), .done(done_a),
        .valid(valid_a), .nack_err(nack_a), .x_pos(x_a), .y_pos(y_a), .status(st_a)
    );

    i2c_master_reader #(.CLK_DIV(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .sda_in(sda_bus),
        .scl_oe(scl_oe_b), .sda_oe(sda_oe_b), .busy(busy_b), .done(done_b),
        .valid(valid_b), .nack_err(nack_b), .x_pos(x_b), .y_pos(y_b), .status(st_b)
    );

    int errors = 0;
    int checks = 0;

    // Slave model: answers reads at s_addr with s_data[0..2], driving on SCL falling edges.
    logic [6:0] s_addr = 7'h64;
    logic [7:0] s_data [0:2];
    logic       p_scl = 1'b1, p_sda = 1'b1;
    logic       s_act = 1'b0, s_rd = 1'b0;
    logic [3:0] s_bit = 4'd0;
    logic [1:0] s_byte = 2'd0;
    logic [7:0] s_sh = 8'h00, s_addr_seen = 8'h00;
    logic [2:0] s_mack = 3'b111;
    int         s_stops = 0;

    always @(posedge clk) begin
        p_scl <= scl_bus;
        p_sda <= sda_bus;
        if (rst) begin
            s_act  <= 1'b0;
            s_pull <= 1'b0;
            s_bit  <= 4'd0;
        end else if (p_scl && scl_bus && p_sda && !sda_bus) begin
            s_act  <= 1'b1;
            s_rd   <= 1'b0;
            s_bit  <= 4'd0;
            s_byte <= 2'd0;
            s_pull <= 1'b0;
            s_mack <= 3'b111;
        end else if (p_scl && scl_bus && !p_sda && sda_bus) begin
            s_act   <= 1'b0;
            s_pull  <= 1'b0;
            s_stops <= s_stops + 1;
        end else if (s_act && !p_scl && scl_bus) begin
            if (!s_rd && s_bit < 4'd8) s_sh <= {s_sh[6:0], sda_bus};
            if (s_rd && s_bit == 4'd8) s_mack[s_byte] <= sda_bus;
            s_bit <= s_bit + 4'd1;
        end else if (s_act && p_scl && !scl_bus) begin
            if (!s_rd) begin
                if (s_bit == 4'd8) begin
                    s_addr_seen <= s_sh;
                    if (s_sh == {s_addr, 1'b1}) s_pull <= 1'b1;
                    else s_act <= 1'b0;
                end else if (s_bit == 4'd9) begin
                    s_rd   <= 1'b1;
                    s_bit  <= 4'd0;
                    s_pull <= ~s_data[0][7];
                end
            end else begin
                if (s_bit == 4'd8) begin
                    s_pull <= 1'b0;
                end else if (s_bit == 4'd9) begin
                    if (!s_mack[s_byte] && s_byte < 2'd2) begin
                        s_byte <= s_byte + 2'd1;
                        s_bit  <= 4'd0;
                        s_pull <= ~s_data[s_byte + 2'd1][7];
                    end else begin
                        s_pull <= 1'b0;
                        s_act  <= 1'b0;
                    end
                end else if (s_bit >= 4'd1 && s_bit <= 4'd7) begin
                    s_pull <= ~s_data[s_byte][3'(7 - s_bit)];
                end
            end
        end
    end

    // Bus monitor: SCL high/low run lengths and SDA edges while SCL stays high.
    int   mon_cd = 4;
    logic m_scl = 1'b1, m_sda = 1'b1;
    int   m_run = 0, hi2 = 0, lo2 = 0, lo_other = 0, hi_edges = 0;

    always @(negedge clk) begin
        m_scl <= scl_bus;
        m_sda <= sda_bus;
        if (scl_bus == m_scl) begin
            m_run <= m_run + 1;
        end else begin
            if (m_scl && m_run == 2 * mon_cd) hi2 <= hi2 + 1;
            if (!m_scl && m_run == 2 * mon_cd) lo2 <= lo2 + 1;
            if (!m_scl && m_run != 2 * mon_cd) lo_other <= lo_other + 1;
            m_run <= 1;
        end
        if (m_scl && scl_bus && (m_sda != sda_bus)) hi_edges <= hi_edges + 1;
    end

    // Pulses start for one cycle; lat counts edges from the accepting edge (=1) to the done cycle.
    task automatic run_txn(input bit use_b, input int max_cyc, output int lat);
        if (use_b) start_b = 1'b1;
        else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        lat = 1;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk); #1;
            lat++;
            if ((use_b ? done_b : done_a) === 1'b1) return;
        end
        lat = -1;
    endtask

    task automatic set_data(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        s_data[0] = b0;
        s_data[1] = b1;
        s_data[2] = b2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({scl_oe_a, sda_oe_a, busy_a, done_a, valid_a, nack_a} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl_a: got %b expected 000000", {scl_oe_a, sda_oe_a, busy_a, done_a, valid_a, nack_a});
        end
        checks++;
        if ({x_a, y_a, st_a} !== 24'h0) begin
            errors++;
            $display("FAIL reset_data_a: got %h expected 000000", {x_a, y_a, st_a});
        end
        checks++;
        if ({scl_oe_b, sda_oe_b, busy_b, done_b, valid_b, nack_b, x_b, y_b, st_b} !== 30'h0) begin
            errors++;
            $display("FAIL reset_b: got %h expected 0", {scl_oe_b, sda_oe_b, busy_b, done_b, valid_b, nack_b, x_b, y_b, st_b});
        end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_basic_read();
        int lat, e0;
        s_addr = 7'h64;
        set_data(8'h5A, 8'hA5, 8'h81);
        mon_cd = 4;
        e0 = hi_edges;
        run_txn(1'b0, 1000, lat);
        checks++;
        if (lat != 610) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 610", lat);
        end
        checks++;
        if ({done_a, valid_a, nack_a, busy_a} !== 4'b1100) begin
            errors++;
            $display("FAIL basic_flags: done/valid/nack/busy got %b expected 1100", {done_a, valid_a, nack_a, busy_a});
        end
        checks++;
        if ({x_a, y_a, st_a} !== 24'h5AA581) begin
            errors++;
            $display("FAIL basic_data: got %h expected 5aa581", {x_a, y_a, st_a});
        end
        checks++;
        if (s_addr_seen !== 8'hC9) begin
            errors++;
            $display("FAIL basic_addr_byte: got %h expected c9", s_addr_seen);
        end
        checks++;
        if (s_mack !== 3'b100) begin
            errors++;
            $display("FAIL basic_master_ack: got %b expected 100", s_mack);
        end
        checks++;
        if (hi_edges - e0 != 2) begin
            errors++;
            $display("FAIL basic_sda_while_scl_high: got %0d edges expected 2", hi_edges - e0);
        end
        @(posedge clk); #1;
        checks++;
        if ({done_a, valid_a} !== 2'b00) begin
            errors++;
            $display("FAIL basic_pulse_width: done/valid got %b expected 00", {done_a, valid_a});
        end
    endtask

    task automatic test_nack();
        int lat, e0, st0;
        s_addr = 7'h65;
        e0 = hi_edges;
        st0 = s_stops;
        run_txn(1'b0, 1000, lat);
        checks++;
        if (lat != 178) begin
            errors++;
            $display("FAIL nack_latency: got %0d expected 178", lat);
        end
        checks++;
        if ({done_a, valid_a, nack_a} !== 3'b101) begin
            errors++;
            $display("FAIL nack_flags: done/valid/nack got %b expected 101", {done_a, valid_a, nack_a});
        end
        checks++;
        if ({x_a, y_a, st_a} !== 24'h5AA581) begin
            errors++;
            $display("FAIL nack_data_held: got %h expected 5aa581", {x_a, y_a, st_a});
        end
        checks++;
        if (s_stops - st0 != 1 || hi_edges - e0 != 2) begin
            errors++;
            $display("FAIL nack_stop: stops %0d edges %0d expected 1 and 2", s_stops - st0, hi_edges - e0);
        end
        s_addr = 7'h64;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_patterns();
        int lat, h0, l0, o0, e0;
        set_data(8'hFF, 8'h00, 8'h80);
        h0 = hi2; l0 = lo2; o0 = lo_other; e0 = hi_edges;
        run_txn(1'b0, 1000, lat);
        checks++;
        if (lat != 610 || {x_a, y_a, st_a} !== 24'hFF0080) begin
            errors++;
            $display("FAIL pattern_data: lat %0d data %h expected 610 ff0080", lat, {x_a, y_a, st_a});
        end
        checks++;
        if (hi2 - h0 != 36) begin
            errors++;
            $display("FAIL pattern_scl_high: got %0d runs of 8 expected 36", hi2 - h0);
        end
        checks++;
        if (lo2 - l0 != 36 || lo_other - o0 != 1) begin
            errors++;
            $display("FAIL pattern_scl_low: got %0d/%0d expected 36/1", lo2 - l0, lo_other - o0);
        end
        checks++;
        if (hi_edges - e0 != 2) begin
            errors++;
            $display("FAIL pattern_sda_while_scl_high: got %0d expected 2", hi_edges - e0);
        end
    endtask

    task automatic test_back_to_back();
        int n, busy_low, n2;
        set_data(8'h12, 8'h34, 8'h56);
        start_a = 1'b1;
        n = 0;
        busy_low = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            n++;
            if (done_a === 1'b1) break;
            if (busy_a !== 1'b1) busy_low++;
        end
        checks++;
        if (n != 610 || busy_low != 0) begin
            errors++;
            $display("FAIL b2b_first: done at %0d busy-low %0d expected 610 0", n, busy_low);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy_at_done: got %b expected 0", busy_a);
        end
        @(posedge clk); #1;
        start_a = 1'b0;
        checks++;
        if ({busy_a, done_a} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_reaccept: busy/done got %b expected 10", {busy_a, done_a});
        end
        n2 = 1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            n2++;
            if (done_a === 1'b1) break;
        end
        checks++;
        if (n2 != 610 || {x_a, y_a, st_a} !== 24'h123456) begin
            errors++;
            $display("FAIL b2b_second: done at %0d data %h expected 610 123456", n2, {x_a, y_a, st_a});
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        set_data(8'h5A, 8'hA5, 8'h81);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (359) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({scl_oe_a, sda_oe_a, busy_a, done_a} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_lines: scl/sda/busy/done got %b expected 0000", {scl_oe_a, sda_oe_a, busy_a, done_a});
        end
        checks++;
        if ({x_a, y_a, st_a} !== 24'h0) begin
            errors++;
            $display("FAIL midreset_data: got %h expected 000000", {x_a, y_a, st_a});
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        run_txn(1'b0, 1000, lat);
        checks++;
        if (lat != 610 || valid_a !== 1'b1 || {x_a, y_a, st_a} !== 24'h5AA581) begin
            errors++;
            $display("FAIL midreset_recover: lat %0d valid %b data %h expected 610 1 5aa581", lat, valid_a, {x_a, y_a, st_a});
        end
    endtask

    task automatic test_clkdiv2();
        int lat, h0;
        set_data(8'h5A, 8'hA5, 8'h81);
        mon_cd = 2;
        h0 = hi2;
        run_txn(1'b1, 1000, lat);
        checks++;
        if (lat != 306) begin
            errors++;
            $display("FAIL div2_latency: got %0d expected 306", lat);
        end
        checks++;
        if ({done_b, valid_b, nack_b} !== 3'b110 || {x_b, y_b, st_b} !== 24'h5AA581) begin
            errors++;
            $display("FAIL div2_data: flags %b data %h expected 110 5aa581", {done_b, valid_b, nack_b}, {x_b, y_b, st_b});
        end
        checks++;
        if (s_mack !== 3'b100 || hi2 - h0 != 36) begin
            errors++;
            $display("FAIL div2_bus: mack %b high runs %0d expected 100 36", s_mack, hi2 - h0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_nack();
        test_patterns();
        test_back_to_back();
        test_reset_mid();
        test_clkdiv2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
